// File: rtl/digit_counter_4.sv
// digit_counter_4: four-digit decimal/hex counter feeding the HEX3..HEX0
// seven-segment decoders. A 26-bit divider turns the board clock into count
// steps; start/stop, clear and load pulses come from debounced keys.
// Optional feature macro: DIGIT_COUNTER_DOWN_EN adds the 'down' input for
// decrementing.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | zeroed after reset/clear, divider stopped
// RUN   | divider advancing, digits step every TICK_DIV cycles
// PAUSE | divider and digits frozen, partial period retained
module digit_counter_4 #(
   parameter int unsigned TICK_DIV = 50000000,
   parameter int unsigned RADIX    = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_stop,
   input  logic        clear,
   input  logic        load,
   input  logic [15:0] load_value,
`ifdef DIGIT_COUNTER_DOWN_EN
   input  logic        down,
`endif
   output logic [15:0] digits,
   output logic        running,
   output logic        tick,
   output logic        wrap
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [25:0] DIV_LAST  = 26'(TICK_DIV - 1);
   localparam logic [3:0]  DIGIT_MAX = 4'(RADIX - 1);

   state_t      state;
   logic [25:0] divider;
   logic [15:0] step_digits;
   logic        step_wrap;
   logic        carry;
   logic        dir_down;

`ifdef DIGIT_COUNTER_DOWN_EN
   assign dir_down = down;
`else
   assign dir_down = 1'b0;
`endif

   // Decimal loads clamp each nibble to 9 so the digits never hold an
   // out-of-range value; hex loads pass straight through.
   function automatic logic [15:0] load_fix(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      if (RADIX == 10) begin
         for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
         end
      end
      return r;
   endfunction

   // Next value for one count step: carry/borrow ripples through all four
   // digits; a carry out of the top digit is the wrap.
   always_comb begin
      step_digits = digits;
      carry       = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (dir_down) begin
               if (digits[4*i +: 4] == 4'd0) begin
                  step_digits[4*i +: 4] = DIGIT_MAX;
               end else begin
                  step_digits[4*i +: 4] = digits[4*i +: 4] - 4'd1;
                  carry = 1'b0;
               end
            end else begin
               if (digits[4*i +: 4] == DIGIT_MAX) begin
                  step_digits[4*i +: 4] = 4'd0;
               end else begin
                  step_digits[4*i +: 4] = digits[4*i +: 4] + 4'd1;
                  carry = 1'b0;
               end
            end
         end
      end
      step_wrap = carry;
   end

   // Control FSM, divider and digit registers; clear beats load beats
   // start_stop, and a clear/load swallows any step due in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         divider <= 26'd0;
         digits  <= 16'h0000;
         running <= 1'b0;
         tick    <= 1'b0;
         wrap    <= 1'b0;
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;
         if (clear) begin
            state   <= IDLE;
            running <= 1'b0;
            divider <= 26'd0;
            digits  <= 16'h0000;
         end else if (load) begin
            divider <= 26'd0;
            digits  <= load_fix(load_value);
         end else begin
            if (start_stop) begin
               case (state)
                  IDLE: begin
                     state   <= RUN;
                     running <= 1'b1;
                  end
                  RUN: begin
                     state   <= PAUSE;
                     running <= 1'b0;
                  end
                  PAUSE: begin
                     state   <= RUN;
                     running <= 1'b1;
                  end
                  default: begin
                     state   <= IDLE;
                     running <= 1'b0;
                  end
               endcase
            end
            if (state == RUN) begin
               if (divider == DIV_LAST) begin
                  divider <= 26'd0;
                  digits  <= step_digits;
                  tick    <= 1'b1;
                  wrap    <= step_wrap;
               end else begin
                  divider <= divider + 26'd1;
               end
            end
         end
      end
   end

endmodule
